// File: rtl/hps_reset_pkg.sv
// Shared types and helpers for the HPS reset-request generator.
package hps_reset_pkg;

   localparam int CNT_W = 26;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_WAIT_ACK,
      ST_WAIT_RELEASE,
      ST_HOLDOFF
   } state_t;

   typedef enum logic [1:0] {
      REQ_COLD  = 2'd0,
      REQ_WARM  = 2'd1,
      REQ_DEBUG = 2'd2
   } req_t;

   // Highest-priority rising source: cold > warm > debug.
   function automatic req_t pick_req(input logic [2:0] rise);
      if (rise[0])      return REQ_COLD;
      else if (rise[1]) return REQ_WARM;
      else              return REQ_DEBUG;
   endfunction

   // True when a source of lower priority than the selected one also rose.
   function automatic logic lower_rise(input logic [2:0] rise, input req_t sel);
      case (sel)
         REQ_COLD: return rise[1] | rise[2];
         REQ_WARM: return rise[2];
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hps_reset_req_gen_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages reset to RST_VAL.
// Latency 2 clk; no backpressure.
module sync_2ff #(
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= {WIDTH{RST_VAL}};
         r_sync <= {WIDTH{RST_VAL}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/hps_reset_req_gen.sv
// Turns rising edges on the exported reset sources into one prioritised active-low HPS reset request pulse.
// Source high at edge N gives req_n low after edge N+3; edges seen while busy are dropped, never queued.
module hps_reset_req_gen
   import hps_reset_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 64,
   parameter int unsigned ACK_TIMEOUT    = 1000000,
   parameter int unsigned HOLDOFF_CYCLES = 1024
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [2:0] issp_src,
   input  logic       h2f_reset_n,
   output logic       f2h_cold_reset_req_n,
   output logic       f2h_warm_reset_req_n,
   output logic       f2h_debug_reset_req_n,
   output logic       busy,
   output logic       req_dropped,
   output logic       ack_timeout
);

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   logic [2:0]       w_src_sync;
   logic [2:0]       r_src_prev;
   logic [2:0]       w_rise;
   logic             w_h2f_sync;

   state_t           r_state;
   state_t           w_state_nxt;
   req_t             r_type;
   req_t             w_type_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ack_timeout;
   logic             w_ack_timeout_nxt;
   logic             r_req_dropped;
   logic             w_req_dropped_nxt;
   logic             r_cold_n;
   logic             r_warm_n;
   logic             r_debug_n;

   sync_2ff #(.WIDTH(3), .RST_VAL(1'b1)) u_src_sync (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_d     (issp_src),
      .o_q     (w_src_sync)
   );

   sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_h2f_sync (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_d     (h2f_reset_n),
      .o_q     (w_h2f_sync)
   );

   // History resets high so a source already asserted at reset release is not an edge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_src_prev <= 3'b111;
      else                r_src_prev <= w_src_sync;
   end

   assign w_rise = w_src_sync & ~r_src_prev;

   always_comb begin
      w_state_nxt       = r_state;
      w_type_nxt        = r_type;
      w_ack_timeout_nxt = r_ack_timeout;
      w_req_dropped_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|w_rise) begin
               w_type_nxt        = pick_req(w_rise);
               w_req_dropped_nxt = lower_rise(w_rise, pick_req(w_rise));
               w_ack_timeout_nxt = 1'b0;
               w_state_nxt       = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            w_req_dropped_nxt = |w_rise;
            if (r_cnt == PULSE_LAST)
               w_state_nxt = (r_type == REQ_DEBUG) ? ST_HOLDOFF : ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            w_req_dropped_nxt = |w_rise;
            if (!w_h2f_sync) begin
               w_state_nxt = ST_WAIT_RELEASE;
            end else if (r_cnt == ACK_LAST) begin
               w_ack_timeout_nxt = 1'b1;
               w_state_nxt       = ST_HOLDOFF;
            end
         end
         ST_WAIT_RELEASE: begin
            w_req_dropped_nxt = |w_rise;
            if (w_h2f_sync) w_state_nxt = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            w_req_dropped_nxt = |w_rise;
            if (r_cnt == HOLDOFF_LAST) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state       <= ST_IDLE;
         r_type        <= REQ_COLD;
         r_cnt         <= '0;
         r_ack_timeout <= 1'b0;
         r_req_dropped <= 1'b0;
         r_cold_n      <= 1'b1;
         r_warm_n      <= 1'b1;
         r_debug_n     <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_type        <= w_type_nxt;
         r_ack_timeout <= w_ack_timeout_nxt;
         r_req_dropped <= w_req_dropped_nxt;
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (r_state != ST_IDLE)
            r_cnt <= r_cnt + CNT_W'(1);
         // Decoded from the current state so each pulse spans exactly the ASSERT residency.
         r_cold_n  <= !((r_state == ST_ASSERT) && (r_type == REQ_COLD));
         r_warm_n  <= !((r_state == ST_ASSERT) && (r_type == REQ_WARM));
         r_debug_n <= !((r_state == ST_ASSERT) && (r_type == REQ_DEBUG));
      end
   end

   assign f2h_cold_reset_req_n  = r_cold_n;
   assign f2h_warm_reset_req_n  = r_warm_n;
   assign f2h_debug_reset_req_n = r_debug_n;
   assign busy                  = (r_state != ST_IDLE);
   assign req_dropped           = r_req_dropped;
   assign ack_timeout           = r_ack_timeout;

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Bench for hps_reset_req_gen: timestamp model of each request checked every cycle, plus directed literal checks.
module tb_hps_reset_req_gen;

   localparam int P     = 4;
   localparam int T     = 32;
   localparam int H     = 8;
   localparam int NEVER = 2147483647;

   logic       clk_clk       = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic [2:0] issp_src      = 3'b000;
   logic       h2f_reset_n   = 1'b1;
   logic       f2h_cold_reset_req_n;
   logic       f2h_warm_reset_req_n;
   logic       f2h_debug_reset_req_n;
   logic       busy;
   logic       req_dropped;
   logic       ack_timeout;

   hps_reset_req_gen #(
      .PULSE_CYCLES   (P),
      .ACK_TIMEOUT    (T),
      .HOLDOFF_CYCLES (H)
   ) dut (
      .clk_clk               (clk_clk),
      .reset_reset_n         (reset_reset_n),
      .issp_src              (issp_src),
      .h2f_reset_n           (h2f_reset_n),
      .f2h_cold_reset_req_n  (f2h_cold_reset_req_n),
      .f2h_warm_reset_req_n  (f2h_warm_reset_req_n),
      .f2h_debug_reset_req_n (f2h_debug_reset_req_n),
      .busy                  (busy),
      .req_dropped           (req_dropped),
      .ack_timeout           (ack_timeout)
   );

   always #10 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each accepted request is described by its acceptance edge and the edge at
   // which the block is free again; input history is kept as plain delayed samples.
   int         e           = 0;
   logic [2:0] xd1         = 3'b111;
   logic [2:0] xd2         = 3'b111;
   logic [2:0] xd3         = 3'b111;
   logic       hd1         = 1'b1;
   logic       hd2         = 1'b1;
   bit         m_active    = 1'b0;
   int         m_a         = 0;
   int         m_type      = 0;
   int         m_wait      = 0;
   int         m_w0        = 0;
   int         m_l         = 0;
   int         m_idle      = NEVER;
   bit         m_tout      = 1'b0;
   bit         m_drop      = 1'b0;

   initial begin
      logic [2:0] r;
      bit         idle;
      forever begin
         @(posedge clk_clk or negedge reset_reset_n);
         if (!reset_reset_n) begin
            xd1 = 3'b111; xd2 = 3'b111; xd3 = 3'b111;
            hd1 = 1'b1;   hd2 = 1'b1;
            m_active = 1'b0; m_wait = 0; m_idle = NEVER;
            m_tout = 1'b0;   m_drop = 1'b0;
         end else begin
            e++;
            r      = xd2 & ~xd3;
            idle   = !m_active || (e > m_idle);
            m_drop = 1'b0;
            if (r != 3'b000) begin
               if (idle) begin
                  m_active = 1'b1;
                  m_a      = e;
                  m_tout   = 1'b0;
                  m_type   = r[0] ? 0 : (r[1] ? 1 : 2);
                  m_drop   = ((r >> (m_type + 1)) != 3'b000);
                  if (m_type == 2) begin
                     m_wait = 0;
                     m_idle = e + P + H;
                  end else begin
                     m_wait = 1;
                     m_w0   = e + P + 1;
                     m_idle = NEVER;
                  end
               end else begin
                  m_drop = 1'b1;
               end
            end
            if (m_wait == 2) begin
               if (e > m_l && hd2) begin
                  m_wait = 0;
                  m_idle = e + H;
               end
            end else if (m_wait == 1 && e >= m_w0) begin
               if (!hd2) begin
                  m_wait = 2;
                  m_l    = e;
               end else if (e - m_w0 == T - 1) begin
                  m_wait = 0;
                  m_tout = 1'b1;
                  m_idle = e + H;
               end
            end
            xd3 = xd2; xd2 = xd1; xd1 = issp_src;
            hd2 = hd1; hd1 = h2f_reset_n;
         end
      end
   end

   initial begin
      bit bz;
      bit low;
      forever begin
         @(negedge clk_clk);
         bz  = m_active && (e >= m_a) && (e < m_idle);
         low = m_active && (e >= m_a + 1) && (e <= m_a + P);
         chk("m_cold_n",  32'(f2h_cold_reset_req_n),  32'(!(low && m_type == 0)));
         chk("m_warm_n",  32'(f2h_warm_reset_req_n),  32'(!(low && m_type == 1)));
         chk("m_debug_n", 32'(f2h_debug_reset_req_n), 32'(!(low && m_type == 2)));
         chk("m_busy",    32'(busy),        32'(bz));
         chk("m_dropped", 32'(req_dropped), 32'(m_drop));
         chk("m_timeout", 32'(ack_timeout), 32'(m_tout));
      end
   end

   // Directed stimulus: tick t counts negedges since the test's source change.
   int t = 0;
   int n_cold = 0, n_warm = 0, n_dbg = 0, n_drop = 0;

   task automatic tick();
      @(negedge clk_clk);
      t++;
      if (!f2h_cold_reset_req_n)  n_cold++;
      if (!f2h_warm_reset_req_n)  n_warm++;
      if (!f2h_debug_reset_req_n) n_dbg++;
      if (req_dropped)            n_drop++;
   endtask

   task automatic run_to(input int target);
      while (t < target) tick();
   endtask

   task automatic start();
      t = 0; n_cold = 0; n_warm = 0; n_dbg = 0; n_drop = 0;
   endtask

   initial begin
      start();
      run_to(3);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_cold_n", 32'(f2h_cold_reset_req_n), 1);
      chk("rst_timeout", 32'(ack_timeout), 0);
      reset_reset_n = 1'b1;
      run_to(8);

      // Cold request with acknowledge
      start();
      issp_src = 3'b001;
      run_to(3);
      chk("cold_pre_low", 32'(f2h_cold_reset_req_n), 1);
      chk("cold_busy",    32'(busy), 1);
      run_to(4);
      chk("cold_first_low", 32'(f2h_cold_reset_req_n), 0);
      run_to(8);
      chk("cold_width", 32'(n_cold), 4);
      run_to(10);
      issp_src = 3'b000;
      run_to(13);
      h2f_reset_n = 1'b0;
      run_to(23);
      h2f_reset_n = 1'b1;
      run_to(33);
      chk("cold_holdoff_busy", 32'(busy), 1);
      run_to(34);
      chk("cold_idle", 32'(busy), 0);
      chk("cold_no_timeout", 32'(ack_timeout), 0);

      // Debug request; h2f activity is irrelevant
      start();
      issp_src = 3'b100;
      run_to(2);
      h2f_reset_n = 1'b0;
      run_to(4);
      chk("dbg_low", 32'(f2h_debug_reset_req_n), 0);
      run_to(6);
      issp_src = 3'b000;
      run_to(8);
      chk("dbg_width", 32'(n_dbg), 4);
      run_to(10);
      h2f_reset_n = 1'b1;
      run_to(14);
      chk("dbg_holdoff_busy", 32'(busy), 1);
      run_to(15);
      chk("dbg_idle", 32'(busy), 0);
      chk("dbg_no_cold", 32'(n_cold), 0);

      // Simultaneous sources, then an edge during HOLDOFF
      start();
      issp_src = 3'b111;
      run_to(3);
      chk("sim_drop", 32'(req_dropped), 1);
      run_to(4);
      chk("sim_drop_once", 32'(req_dropped), 0);
      chk("sim_cold_low", 32'(f2h_cold_reset_req_n), 0);
      run_to(8);
      h2f_reset_n = 1'b0;
      run_to(10);
      issp_src = 3'b000;
      run_to(11);
      h2f_reset_n = 1'b1;
      run_to(15);
      issp_src = 3'b010;
      run_to(18);
      chk("holdoff_drop", 32'(req_dropped), 1);
      run_to(20);
      issp_src = 3'b000;
      run_to(25);
      chk("sim_drop_count", 32'(n_drop), 2);
      chk("sim_cold_width", 32'(n_cold), 4);
      chk("sim_no_warm",  32'(n_warm), 0);
      chk("sim_no_dbg",   32'(n_dbg), 0);
      chk("sim_idle",     32'(busy), 0);

      // Warm request with no acknowledge
      start();
      issp_src = 3'b010;
      run_to(6);
      issp_src = 3'b000;
      run_to(38);
      chk("to_not_yet", 32'(ack_timeout), 0);
      run_to(39);
      chk("to_set", 32'(ack_timeout), 1);
      chk("to_warm_width", 32'(n_warm), 4);
      run_to(50);
      chk("to_sticky", 32'(ack_timeout), 1);
      chk("to_idle",   32'(busy), 0);

      // New request clears the flag; reset mid-pulse; source held through reset release
      start();
      issp_src = 3'b001;
      run_to(3);
      chk("to_cleared", 32'(ack_timeout), 0);
      run_to(4);
      chk("mid_cold_low", 32'(f2h_cold_reset_req_n), 0);
      #2 reset_reset_n = 1'b0;
      #1;
      chk("async_clr_cold", 32'(f2h_cold_reset_req_n), 1);
      chk("async_clr_busy", 32'(busy), 0);
      run_to(7);
      reset_reset_n = 1'b1;
      start();
      run_to(20);
      chk("held_no_pulse", 32'(n_cold), 0);
      chk("held_not_busy", 32'(busy), 0);
      issp_src = 3'b000;
      run_to(24);
      start();
      issp_src = 3'b001;
      run_to(4);
      chk("rearm_cold_low", 32'(f2h_cold_reset_req_n), 0);
      run_to(8);
      chk("rearm_width", 32'(n_cold), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
